// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential significand divider.
package div_pkg;
  localparam int MW = 24;       // significand width incl. hidden bit
  localparam int QW = MW + 2;   // quotient: integer bit, fraction bits, guard
  localparam int RW = MW + 2;   // residual width; residual stays below 2B

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mantissa_divider_seq_if.sv
// Request/result bundle between the exponent stage, the divider and normalize/round.
interface mantissa_divider_seq_if;
  import div_pkg::*;

  // Handshake: start is taken only on an edge where busy==0; busy stays high
  // until done has been shown for one cycle; q/sticky/dbz are valid while done
  // is high and hold until the next accepted start.
  logic          start;
  logic [MW-1:0] a;
  logic [MW-1:0] b;
  logic          busy;
  logic          done;
  logic [QW-1:0] q;
  logic          sticky;
  logic          dbz;
  state_t        dbg_state;

  modport master (
    output start, a, b,
    input  busy, done, q, sticky, dbz, dbg_state
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, sticky, dbz, dbg_state
  );
endinterface

// File: rtl/mant_sub_26bit.sv
// Trial difference R - B built as negate-then-add; non_neg is the inverted sign bit.
module mant_sub_26bit
  import div_pkg::*;
(
  input  logic [RW-1:0] r,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] diff,
  output logic          non_neg
);
  logic [RW-1:0] b_neg;

  assign b_neg   = ~b + RW'(1);
  assign diff    = r + b_neg;
  assign non_neg = ~diff[RW-1];
endmodule

// File: rtl/mantissa_divider_seq.sv
// Restoring significand divider: one quotient bit per clock, sticky from the final residual.
module mantissa_divider_seq
  import div_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  mantissa_divider_seq_if.slave  bus
);
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);

  state_t        state_q, state_d;
  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] b_q, b_d;
  logic [QW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
  logic          dbz_q, dbz_d;

  logic [RW-1:0] diff;
  logic          non_neg;
  logic [RW-1:0] sel;

  mant_sub_26bit u_sub (
    .r       (r_q),
    .b       (b_q),
    .diff    (diff),
    .non_neg (non_neg)
  );

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    b_d      = b_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    dbz_d    = dbz_q;
    sel      = non_neg ? diff : r_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          r_d      = {2'b00, bus.a};
          b_d      = {2'b00, bus.b};
          dbz_d    = (bus.b == '0);
          q_d      = '0;
          sticky_d = 1'b0;
          cnt_d    = CNT_LAST;
        end
      end
      RUN: begin
        q_d   = {q_q[QW-2:0], non_neg};
        r_d   = {sel[RW-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d  = DONE;
          cnt_d    = '0;
          sticky_d = (sel != '0) && !dbz_q;
          // A zero divisor reports saturated quotient; timing is left untouched.
          if (dbz_q) q_d = '1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      r_q      <= '0;
      b_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      b_q      <= b_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.q         = q_q;
  assign bus.sticky    = sticky_q;
  assign bus.dbz       = dbz_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mantissa_divider_seq.sv
// Scoreboard bench: driver pushes arithmetic-model results, monitor pops on done.
module tb_mantissa_divider_seq;
  import div_pkg::*;

  localparam int EW = QW + 2;  // {q, sticky, dbz}

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  logic          hold_pending = 1'b0;
  logic [QW-1:0] held_q;

  mantissa_divider_seq_if bus_if ();

  mantissa_divider_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: quotient and remainder of a*2^(QW-1) / b by plain integer arithmetic.
  function automatic logic [EW-1:0] ref_div(input logic [MW-1:0] a, input logic [MW-1:0] b);
    longint unsigned num, qv, rem;
    logic [QW-1:0]   qbits;
    if (b == '0) return {{QW{1'b1}}, 1'b0, 1'b1};
    num   = longint'(a) << (QW - 1);
    qv    = num / longint'(b);
    rem   = num % longint'(b);
    qbits = qv[QW-1:0];
    return {qbits, (rem != 0), 1'b0};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic [MW-1:0] a, input logic [MW-1:0] b, input bit expect_result);
    int n = 0;
    @(negedge clk);
    while (bus_if.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("busy_wait_timeout", bus_if.busy, 0);
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check("busy_after_accept", bus_if.busy, 1);
    if (expect_result) begin
      exp_q.push_back(ref_div(a, b));
      exp_cyc_q.push_back(cyc + QW);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (hold_pending) begin
      hold_pending <= 1'b0;
      check("q_hold_after_done", bus_if.q, held_q);
      check("done_one_cycle", bus_if.done, 0);
      check("busy_drop_after_done", bus_if.busy, 0);
    end
    if (!rst && bus_if.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        logic [EW-1:0] e;
        int            ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("q", bus_if.q, e[EW-1:2]);
        check("sticky", bus_if.sticky, e[1]);
        check("dbz", bus_if.dbz, e[0]);
        check("done_latency", cyc, ec);
        check("busy_during_done", bus_if.busy, 1);
        held_q       <= bus_if.q;
        hold_pending <= 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [MW-1:0] ra, rb;
    int n;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.a     = '0;
    bus_if.b     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", bus_if.busy, 0);
    check("reset_done", bus_if.done, 0);
    check("reset_q", bus_if.q, 0);
    check("reset_sticky", bus_if.sticky, 0);
    check("reset_dbz", bus_if.dbz, 0);
    check("reset_state", bus_if.dbg_state, IDLE);

    issue(24'h800000, 24'h800000, 1);
    issue(24'hC00000, 24'h800000, 1);
    issue(24'h800000, 24'hC00000, 1);

    // Start pulsed at E5 of a running operation must be ignored.
    issue(24'hFFFFFF, 24'h800000, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus_if.a     = 24'h812345;
    bus_if.b     = 24'h900000;
    bus_if.start = 1'b1;
    @(posedge clk);
    #1 bus_if.start = 1'b0;

    issue(24'h9A0000, 24'h000000, 1);

    // Abort mid-operation with reset: no done may follow.
    issue(24'h800000, 24'hC00000, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", bus_if.busy, 0);
    check("abort_done", bus_if.done, 0);
    check("abort_q", bus_if.q, 0);
    check("abort_sticky", bus_if.sticky, 0);
    check("abort_dbz", bus_if.dbz, 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    issue(24'h800000, 24'hC00000, 1);

    for (int i = 0; i < 40; i++) begin
      ra = MW'($urandom_range(24'hFFFFFF, 24'h800000));
      if ($urandom_range(7, 0) == 0) rb = '0;
      else rb = MW'($urandom_range(24'hFFFFFF, 24'h800000));
      issue(ra, rb, 1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mantissa_divider_seq.md
# mantissa_divider_seq

Sequential restoring divider for IEEE754 single-precision significands in the division datapath. It sits directly downstream of the significand unpack/exponent stage and consumes two normalized significands (hidden bit included). It produces one quotient bit per clock by trial subtraction, using the team's two's-complement negate-and-add building blocks. Its quotient and sticky bit feed the normalize/round stage.

## Interface
Parameters:
- MW, 24: significand width including the hidden bit.
- QW, MW+2 = 26: quotient width (integer bit, fraction bits, guard).

Ports:
- clk  in  1  rising-edge clock. One clock domain.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- a  in  MW  dividend significand.
- b  in  MW  divisor significand.
- busy  out  1  high from the accepting edge until done deasserts.
- done  out  1  one-cycle pulse: result is valid.
- q  out  QW  quotient, floor(a·2^(QW-1)/b).
- sticky  out  1  high when the final residual is nonzero.
- dbz  out  1  divide-by-zero: b == 0 at accept.

## Operation
- FSM states:
  - IDLE: start=1 → RUN. Loads R=a (MW+2 bits), latches B=b and dbz=(b==0), clears q, sets cnt=QW-1.
  - RUN: on each edge, T = R + (~{00,B} + 1).
    - T non-negative (MSB 0): shift 1 into q and set R = T<<1.
    - Otherwise: shift 0 into q and set R = R<<1.
    - cnt decrements. On the edge where cnt==0, sticky = (selected residual before shift != 0) and state → DONE.
  - DONE: done=1 for exactly one cycle, then → IDLE.
- Width rules:
  - Normalized inputs (a, b in [2^(MW-1), 2^MW)) give a quotient in (2^(QW-2), 2^QW). Either q[QW-1] or q[QW-2] is set. The downstream stage normalizes.
  - The residual always stays below 2B, so MW+2 bits never overflow.
- dbz=1: in DONE, q is forced to all ones and sticky=0. The cycle count is unchanged.
- Unnormalized nonzero b is outside the contract. The output is the raw restoring result and no flag is raised.
- start while busy is ignored. There is no queuing and the latched operands stay unchanged.
- q, sticky and dbz hold their values from done until the next accepted start.

## Timing
- Reset values: state=IDLE; busy=0, done=0, q=0, sticky=0, dbz=0, cnt=0.
- rst during RUN or DONE: the next edge returns the block to IDLE with all outputs at reset values. No done pulse is emitted.
- Latency: start is accepted at edge E0. Quotient bits are produced at E1..E(QW). done is high in the cycle following E(QW) and drops at E(QW+1).
- busy is high from E0 through E(QW+1). start is accepted again at the first edge where busy=0, giving QW+2 cycles per operation.
- start and rst in the same cycle: rst wins.

## Structure
- Shared package div_pkg holds:
  - constants MW=24 and QW=26;
  - the 2-bit state encoding IDLE/RUN/DONE;
  - residual width localparam RW=MW+2.
- One sub-module, mant_sub_26bit. It computes the trial difference R − B and returns a non-negative flag. It is built from the existing 26-bit two's-complement negate and adder primitives, and is instantiated once. The remainder of the block is the FSM, the counter and the shift registers.

## Test plan
- a=0x800000, b=0x800000 → done at E26: q=0x2000000, sticky=0, dbz=0.
- a=0xC00000, b=0x800000 → q=0x3000000, sticky=0.
- a=0x800000, b=0xC00000 → q=0x1555555, sticky=1.
- a=0xFFFFFF, b=0x800000 → q=0x3FFFFFC, sticky=0. In the same run, start pulsed at E5 is ignored and the result is unchanged.
- b=0x000000, a=0x9A0000 → q=0x3FFFFFF, sticky=0, dbz=1, with done still at E26.
- rst asserted at E10 of an operation → outputs at reset values from E11 and no done pulse. A new start then yields the correct result; checked with the test 3 operands.
